user_reg_responder: RTL and testbench
=====================================

USER_REG_RESPONDER -- requirements
Module: user_reg_responder

Interface
REQ-001 Parameter NUM_REGS, default 16: number of implemented 32-bit parameter registers (1..256).
REQ-002 Parameter READ_LATENCY, default 2: cycles from accepted read to ReadDataValid (1..4).
REQ-003 clk  in  1  sole clock; all state on rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 hostRegWriteEn  in  1  host-side register write strobe.
REQ-006 hostRegAddr  in  8  host write address.
REQ-007 hostRegWriteData  in  32  host write data.
REQ-008 hostRunSet  in  1  one-cycle pulse: start user run.
REQ-009 userRunValue  out  1  run register value.
REQ-010 userRunClear  in  1  user request to clear run register.
REQ-011 register32CmdReq  in  1  user command request.
REQ-012 register32CmdAck  out  1  command accept; req&&ack in one cycle = accepted.
REQ-013 register32Address  in  8  user command address.
REQ-014 register32WriteEn  in  1  1 = write command, 0 = read command.
REQ-015 register32WriteData  in  32  user write data.
REQ-016 register32ReadDataValid  out  1  one-cycle pulse per accepted read.
REQ-017 register32ReadData  out  32  read data, meaningful only while ReadDataValid=1.

Function
REQ-018 register32CmdAck SHALL be combinational: 1 when reset_n=1 and hostRegWriteEn=0, else 0 (host has priority).
REQ-019 One command SHALL be accepted per cycle while req stays high; back-to-back reads SHALL be fully pipelined, no bubbles.
REQ-020 Accepted read SHALL sample register[register32Address] at the accept edge into a READ_LATENCY-deep valid/data pipeline; ReadDataValid pulses exactly READ_LATENCY cycles later.
REQ-021 Read results SHALL return in acceptance order, one per accepted read, never merged or dropped.
REQ-022 Host writes after a read is accepted SHALL NOT alter that read's returned data (snapshot at accept).
REQ-023 Accepted write SHALL update register[address] at the accept edge; no ReadDataValid produced.
REQ-024 Read accepted the cycle after any write to the same address SHALL return the new value.
REQ-025 Host write with hostRegWriteEn=1 SHALL update register[hostRegAddr] at that edge.
REQ-026 Address >= NUM_REGS: read SHALL return 32'd0 with normal latency; write SHALL be ignored; command still acked.
REQ-027 Run register: hostRunSet=1 sets to 1; else userRunClear=1 clears to 0; simultaneous SHALL resolve to 1 (set wins).
REQ-028 userRunValue SHALL equal the run register directly (no extra latency).
REQ-029 Reads in flight SHALL complete even if userRunClear or hostRunSet occurs meanwhile.
REQ-030 ReadData SHALL be 0 whenever ReadDataValid=0.

Reset
REQ-031 reset_n=0 SHALL immediately clear all registers to 0, run register to 0, and pipeline valids to 0, independent of clk.
REQ-032 During reset: CmdAck=0, ReadDataValid=0, ReadData=0, userRunValue=0.
REQ-033 Reset mid-operation SHALL drop all pending read returns; none appear after reset_n rises.
REQ-034 First command SHALL be acceptable in the first clk edge after reset_n deasserts.

Verification
REQ-035 Host writes reg0=0x0000_0005, reg1=0x0000_0009; user holds req, reads addr 0,1 back-to-back -> acks on 2 consecutive cycles, ValidData 0x5 then 0x9 at +2/+3 cycles.
REQ-036 User read addr 3 accepted, host writes reg3=0xDEAD_BEEF next cycle -> returned data is old value 0x0; read issued after returns 0xDEAD_BEEF.
REQ-037 User req held while hostRegWriteEn=1 for 2 cycles -> CmdAck=0 those cycles, accepts resume after; no lost/duplicate ReadDataValid.
REQ-038 Read addr 0x20 with NUM_REGS=16 -> ack, ReadData=0 valid at +2; write to 0x20 leaves all regs unchanged.
REQ-039 hostRunSet and userRunClear same cycle -> userRunValue=1; userRunClear alone next cycle -> 0.
REQ-040 Two reads in flight, reset_n pulsed low asynchronously mid-cycle -> outputs 0 at once, no ReadDataValid after release, all regs read 0.

Source files
------------

// File: rtl/user_reg_responder.sv
`default_nettype none
// ==========================================================================
// user_reg_responder : parameter register file with a pipelined user
// read/write command port, a priority host write port and a run flag.
// Rev 1.0
// ==========================================================================
module user_reg_responder #(
  parameter int NUM_REGS     = 16,
  parameter int READ_LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        hostRegWriteEn,
  input  logic [7:0]  hostRegAddr,
  input  logic [31:0] hostRegWriteData,
  input  logic        hostRunSet,
  output logic        userRunValue,
  input  logic        userRunClear,
  input  logic        register32CmdReq,
  output logic        register32CmdAck,
  input  logic [7:0]  register32Address,
  input  logic        register32WriteEn,
  input  logic [31:0] register32WriteData,
  output logic        register32ReadDataValid,
  output logic [31:0] register32ReadData
);

  logic [31:0]             r_regs [NUM_REGS];
  logic                    r_run;
  logic [READ_LATENCY-1:0] r_pipeValid;
  logic [31:0]             r_pipeData [READ_LATENCY];

  logic        w_accept;
  logic        w_rdAccept;
  logic        w_wrEn;
  logic [7:0]  w_wrAddr;
  logic [31:0] w_wrData;
  logic [31:0] w_rdData;

  assign register32CmdAck = reset_n & ~hostRegWriteEn;
  assign w_accept         = register32CmdReq & register32CmdAck;
  assign w_rdAccept       = w_accept & ~register32WriteEn;

  // Host and user writes never collide: user commands are refused while the host writes.
  assign w_wrEn   = hostRegWriteEn | (w_accept & register32WriteEn);
  assign w_wrAddr = hostRegWriteEn ? hostRegAddr      : register32Address;
  assign w_wrData = hostRegWriteEn ? hostRegWriteData : register32WriteData;

  // Unimplemented addresses match no register and read back as zero.
  always_comb begin
    w_rdData = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (register32Address == 8'(i)) w_rdData = r_regs[i];
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_regs
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_regs[gi] <= '0;
        end else if (w_wrEn && (w_wrAddr == 8'(gi))) begin
          r_regs[gi] <= w_wrData;
        end
      end
    end
  endgenerate

  // Data stages carry zero alongside an empty valid so the output needs no masking.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pipeValid <= '0;
      for (int s = 0; s < READ_LATENCY; s++) r_pipeData[s] <= '0;
    end else begin
      r_pipeValid[0] <= w_rdAccept;
      r_pipeData[0]  <= w_rdAccept ? w_rdData : 32'd0;
      for (int s = 1; s < READ_LATENCY; s++) begin
        r_pipeValid[s] <= r_pipeValid[s-1];
        r_pipeData[s]  <= r_pipeData[s-1];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_run <= 1'b0;
    end else if (hostRunSet) begin
      r_run <= 1'b1;
    end else if (userRunClear) begin
      r_run <= 1'b0;
    end
  end

  assign userRunValue            = r_run;
  assign register32ReadDataValid = r_pipeValid[READ_LATENCY-1];
  assign register32ReadData      = r_pipeData[READ_LATENCY-1];

endmodule
`default_nettype wire

// File: tb/tb_user_reg_responder.sv
`default_nettype none
// ==========================================================================
// tb_user_reg_responder : directed self-checking bench for user_reg_responder.
// Rev 1.0
// ==========================================================================
module tb_user_reg_responder;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        hostRegWriteEn;
  logic [7:0]  hostRegAddr;
  logic [31:0] hostRegWriteData;
  logic        hostRunSet;
  logic        userRunValue;
  logic        userRunClear;
  logic        register32CmdReq;
  logic        register32CmdAck;
  logic [7:0]  register32Address;
  logic        register32WriteEn;
  logic [31:0] register32WriteData;
  logic        register32ReadDataValid;
  logic [31:0] register32ReadData;

  int nChecks = 0;
  int nFails  = 0;
  logic [31:0] expRegs [16];

  user_reg_responder #(.NUM_REGS(16), .READ_LATENCY(2)) dut (
    .clk                    (clk),
    .reset_n                (reset_n),
    .hostRegWriteEn         (hostRegWriteEn),
    .hostRegAddr            (hostRegAddr),
    .hostRegWriteData       (hostRegWriteData),
    .hostRunSet             (hostRunSet),
    .userRunValue           (userRunValue),
    .userRunClear           (userRunClear),
    .register32CmdReq       (register32CmdReq),
    .register32CmdAck       (register32CmdAck),
    .register32Address      (register32Address),
    .register32WriteEn      (register32WriteEn),
    .register32WriteData    (register32WriteData),
    .register32ReadDataValid(register32ReadDataValid),
    .register32ReadData     (register32ReadData)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nFails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOut(input string tag, input logic v, input logic [31:0] d);
    checkVal({tag, "_valid"}, {31'd0, register32ReadDataValid}, {31'd0, v});
    checkVal({tag, "_data"}, register32ReadData, d);
  endtask

  task automatic hostWrite(input logic [7:0] a, input logic [31:0] d);
    hostRegWriteEn = 1'b1; hostRegAddr = a; hostRegWriteData = d;
    tick();
    hostRegWriteEn = 1'b0;
  endtask

  // Pipelined sweep of all registers; each tick shows the read accepted one edge earlier.
  task automatic readAllCheck(input string tag);
    register32CmdReq = 1'b1; register32WriteEn = 1'b0;
    for (int i = 0; i < 16; i++) begin
      register32Address = 8'(i);
      tick();
      if (i == 0) checkOut($sformatf("%s_idle", tag), 1'b0, 32'd0);
      else        checkOut($sformatf("%s_r%0d", tag, i - 1), 1'b1, expRegs[i-1]);
    end
    register32CmdReq = 1'b0;
    tick();
    checkOut($sformatf("%s_r15", tag), 1'b1, expRegs[15]);
    tick();
    checkOut($sformatf("%s_end", tag), 1'b0, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) expRegs[i] = 32'd0;
    reset_n = 1'b0;
    hostRegWriteEn = 1'b0; hostRegAddr = '0; hostRegWriteData = '0;
    hostRunSet = 1'b0; userRunClear = 1'b0;
    register32CmdReq = 1'b1; register32Address = 8'd2;
    register32WriteEn = 1'b1; register32WriteData = 32'h0000_1234;

    // Reset state
    #12;
    checkVal("rst_ack", {31'd0, register32CmdAck}, 32'd0);
    checkOut("rst", 1'b0, 32'd0);
    checkVal("rst_run", {31'd0, userRunValue}, 32'd0);

    // First command accepted on the first edge after release
    #5 reset_n = 1'b1;
    #1 checkVal("first_ack", {31'd0, register32CmdAck}, 32'd1);
    tick();
    register32CmdReq = 1'b0; register32WriteEn = 1'b0;
    expRegs[2] = 32'h0000_1234;

    // Back-to-back reads after host writes
    hostWrite(8'd0, 32'h0000_0005); expRegs[0] = 32'h5;
    hostWrite(8'd1, 32'h0000_0009); expRegs[1] = 32'h9;
    register32CmdReq = 1'b1; register32Address = 8'd0;
    #1 checkVal("b2b_ack0", {31'd0, register32CmdAck}, 32'd1);
    tick();
    checkOut("b2b_lat1", 1'b0, 32'd0);
    register32Address = 8'd1;
    #1 checkVal("b2b_ack1", {31'd0, register32CmdAck}, 32'd1);
    tick();
    register32CmdReq = 1'b0;
    checkOut("b2b_r0", 1'b1, 32'h5);
    tick();
    checkOut("b2b_r1", 1'b1, 32'h9);
    tick();
    checkOut("b2b_end", 1'b0, 32'd0);

    // Snapshot at accept: host write after the read must not show
    register32CmdReq = 1'b1; register32Address = 8'd3;
    tick();
    register32CmdReq = 1'b0;
    hostWrite(8'd3, 32'hDEAD_BEEF); expRegs[3] = 32'hDEAD_BEEF;
    checkOut("snap_old", 1'b1, 32'd0);
    tick();
    register32CmdReq = 1'b1;
    tick();
    register32CmdReq = 1'b0;
    tick();
    checkOut("snap_new", 1'b1, 32'hDEAD_BEEF);

    // User write then read of the same address on the next cycle
    register32CmdReq = 1'b1; register32WriteEn = 1'b1;
    register32Address = 8'd4; register32WriteData = 32'h0000_A5A5;
    tick();
    register32WriteEn = 1'b0;
    tick();
    register32CmdReq = 1'b0;
    checkOut("wr_nodv", 1'b0, 32'd0);
    tick();
    checkOut("wr_rd", 1'b1, 32'h0000_A5A5);
    expRegs[4] = 32'h0000_A5A5;
    tick();

    // Host priority stalls held request for two cycles
    register32CmdReq = 1'b1; register32Address = 8'd0;
    tick();
    checkOut("stall_a0", 1'b0, 32'd0);
    hostRegWriteEn = 1'b1; hostRegAddr = 8'd5; hostRegWriteData = 32'd7;
    #1 checkVal("stall_ack1", {31'd0, register32CmdAck}, 32'd0);
    tick();
    checkOut("stall_r0", 1'b1, 32'h5);
    hostRegAddr = 8'd6; hostRegWriteData = 32'd8;
    #1 checkVal("stall_ack2", {31'd0, register32CmdAck}, 32'd0);
    tick();
    checkOut("stall_a2", 1'b0, 32'd0);
    hostRegWriteEn = 1'b0; register32Address = 8'd1;
    #1 checkVal("stall_ack3", {31'd0, register32CmdAck}, 32'd1);
    tick();
    register32CmdReq = 1'b0;
    checkOut("stall_a3", 1'b0, 32'd0);
    tick();
    checkOut("stall_r1", 1'b1, 32'h9);
    tick();
    checkOut("stall_end", 1'b0, 32'd0);
    expRegs[5] = 32'd7; expRegs[6] = 32'd8;

    // Out-of-range read and ignored writes
    register32CmdReq = 1'b1; register32Address = 8'h20;
    #1 checkVal("oor_ack", {31'd0, register32CmdAck}, 32'd1);
    tick();
    register32WriteEn = 1'b1; register32WriteData = 32'hFFFF_FFFF;
    tick();
    register32CmdReq = 1'b0; register32WriteEn = 1'b0;
    checkOut("oor_rd", 1'b1, 32'd0);
    hostWrite(8'h10, 32'h1111_1111);
    checkOut("oor_nodv", 1'b0, 32'd0);
    readAllCheck("regs");

    // Run register with a read in flight
    register32CmdReq = 1'b1; register32Address = 8'd2;
    hostRunSet = 1'b1; userRunClear = 1'b1;
    tick();
    register32CmdReq = 1'b0; hostRunSet = 1'b0;
    checkVal("run_setwins", {31'd0, userRunValue}, 32'd1);
    tick();
    userRunClear = 1'b0;
    checkVal("run_clear", {31'd0, userRunValue}, 32'd0);
    checkOut("run_rd", 1'b1, 32'h0000_1234);
    hostRunSet = 1'b1;
    tick();
    hostRunSet = 1'b0;
    checkVal("run_set", {31'd0, userRunValue}, 32'd1);

    // Asynchronous reset with two reads in flight
    register32CmdReq = 1'b1; register32Address = 8'd0;
    tick();
    register32Address = 8'd1;
    tick();
    checkOut("arst_pre", 1'b1, 32'h5);
    #2 reset_n = 1'b0;
    #1;
    checkOut("arst", 1'b0, 32'd0);
    checkVal("arst_ack", {31'd0, register32CmdAck}, 32'd0);
    checkVal("arst_run", {31'd0, userRunValue}, 32'd0);
    register32CmdReq = 1'b0;
    #3 reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOut($sformatf("arst_drop%0d", i), 1'b0, 32'd0);
    end
    for (int i = 0; i < 16; i++) expRegs[i] = 32'd0;
    readAllCheck("zero");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nChecks, nFails);
    $finish;
  end

endmodule
`default_nettype wire
